// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller with frame-synchronous digit update
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   load       single-cycle strobe capturing digits_in into the pending register
//   digits_in  NUM_DIGITS BCD nibbles, nibble i at [4i+3:4i], top nibble most significant
//   digit_en   per-digit enable, 0 forces that digit dark
//   blank_lz   1 enables leading-zero blanking (digit 0 is never blanked)
//   encoded    nibble for the downstream cathode decoder, 4'hF when dark
//   anode      active-low one-hot digit select, all ones when dark
//   frame_done one-cycle pulse in the first cycle of each new scan
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      blank_lz,
    output logic [3:0]                encoded,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } phase_t;

    logic [CW-1:0]           div_cnt;
    logic [IW-1:0]           idx;
    phase_t                  phase;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_valid;

    logic          slot_wrap;
    logic          frame_wrap;
    logic [CW-1:0] next_cnt;

    assign slot_wrap  = (div_cnt == LAST_CNT);
    assign frame_wrap = slot_wrap && (idx == LAST_IDX);
    assign next_cnt   = slot_wrap ? '0 : div_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt       <= '0;
            idx           <= '0;
            phase         <= BLANK;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            div_cnt    <= next_cnt;
            // Phase is derived from the counter value it will sit beside,
            // so the registered phase always agrees with div_cnt.
            phase      <= (next_cnt < BLANK_END) ? BLANK : SHOW;
            frame_done <= frame_wrap;
            if (slot_wrap) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            // The active register only changes at a frame boundary so a
            // frame never mixes two loaded values.
            if (frame_wrap && pending_valid) begin
                active        <= pending;
                pending_valid <= 1'b0;
            end
            // A load on the boundary edge still lands in pending; active has
            // already taken the previous pending contents above.
            if (load) begin
                pending       <= digits_in;
                pending_valid <= 1'b1;
            end
        end
    end

    // Leading-zero detection: the current digit is blanked when it and every
    // more significant nibble are zero.
    logic       upper_nonzero;
    logic       lz_blank;
    logic       lit;
    logic [3:0] cur_nib;

    always_comb begin
        upper_nonzero = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((IW'(j) >= idx) && (active[4*j +: 4] != 4'd0)) begin
                upper_nonzero = 1'b1;
            end
        end
        lz_blank = blank_lz && (idx != '0) && !upper_nonzero;
        cur_nib  = active[{idx, 2'b00} +: 4];
        lit      = (phase == SHOW) && digit_en[idx] && !lz_blank;
    end

    assign anode   = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    assign encoded = lit ? cur_nib : 4'hF;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized and directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int F = N * R;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  en = 4'hF;
    logic        blz = 1'b0;
    logic [3:0]  encoded;
    logic [3:0]  anode;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time since reset plus the two digit registers.
    int          c = 0;
    logic [15:0] act = '0;
    logic [15:0] pend = '0;
    logic        pv = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (din),
        .digit_en  (en),
        .blank_lz  (blz),
        .encoded   (encoded),
        .anode     (anode),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (model cycle %0d)", tag, obs, exp, c);
        end
    endtask

    task automatic compare_model();
        int         div;
        int         d;
        logic       lz;
        logic       lit;
        logic [3:0] sel;
        logic [3:0] ea;
        logic [3:0] ee;
        div = c % R;
        d   = (c / R) % N;
        lz  = blz && (d != 0) && ((act >> (4 * d)) == 16'd0);
        lit = (div >= B) && en[d] && !lz;
        sel = 4'b0001 << d;
        ea  = lit ? ~sel : 4'hF;
        ee  = lit ? 4'((act >> (4 * d)) & 16'hF) : 4'hF;
        check("anode", anode, ea);
        check("encoded", encoded, ee);
        check("frame_done", frame_done, (c != 0) && (c % F == 0));
    endtask

    task automatic cycle(input logic r, input logic l, input logic [15:0] d);
        rst  = r;
        load = l;
        din  = d;
        @(posedge clk);
        if (r) begin
            c    = 0;
            act  = '0;
            pend = '0;
            pv   = 1'b0;
        end else begin
            if (((c + 1) % F == 0) && pv) begin
                act = pend;
                pv  = 1'b0;
            end
            if (l) begin
                pend = d;
                pv   = 1'b1;
            end
            c++;
        end
        #1;
        compare_model();
        rst  = 1'b0;
        load = 1'b0;
    endtask

    task automatic run_to(input int t);
        for (int i = 0; i < F; i++) begin
            cycle(1'b0, 1'b0, din);
            if (c % F == t) break;
        end
        check("run_to_reached", c % F, t);
    endtask

    initial begin
        cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 16'hABCD);
        check("reset_anode", anode, 4'hF);
        check("reset_encoded", encoded, 4'hF);

        // Basic scan of 4321.
        cycle(1'b0, 1'b1, 16'h4321);
        run_to(0);
        check("first_frame_done", frame_done, 1'b1);
        cycle(1'b0, 1'b0, din);
        check("slot0_blank_anode", anode, 4'hF);
        cycle(1'b0, 1'b0, din);
        check("slot0_show_anode", anode, 4'b1110);
        check("slot0_show_encoded", encoded, 4'h1);

        // Leading-zero blanking.
        blz = 1'b1;
        cycle(1'b0, 1'b1, 16'h0050);
        run_to(0);
        run_to(3 * R + 3);
        check("lz_digit3_anode", anode, 4'hF);
        check("lz_digit3_encoded", encoded, 4'hF);
        run_to(R + 3);
        check("lz_digit1_anode", anode, 4'b1101);
        check("lz_digit1_encoded", encoded, 4'h5);
        cycle(1'b0, 1'b1, 16'h0000);
        run_to(0);
        run_to(3);
        check("zero_digit0_encoded", encoded, 4'h0);
        check("zero_digit0_anode", anode, 4'b1110);
        run_to(R + 3);
        check("zero_digit1_anode", anode, 4'hF);
        blz = 1'b0;

        // Two loads in one frame: only the last survives, applied at the boundary.
        run_to(10);
        cycle(1'b0, 1'b1, 16'h1111);
        run_to(30);
        cycle(1'b0, 1'b1, 16'h2222);
        run_to(3);
        check("last_load_wins", encoded, 4'h2);

        // Load on the wrap edge while pending holds 5555.
        run_to(5);
        cycle(1'b0, 1'b1, 16'h5555);
        run_to(31);
        cycle(1'b0, 1'b1, 16'h9876);
        run_to(3);
        check("wrap_load_old", encoded, 4'h5);
        run_to(0);
        run_to(3);
        check("wrap_load_new", encoded, 4'h6);

        // Per-digit enables.
        en = 4'b0101;
        run_to(R + 3);
        check("en_off_anode", anode, 4'hF);
        check("en_off_encoded", encoded, 4'hF);
        run_to(2 * R + 3);
        check("en_on_encoded", encoded, 4'h8);
        en = 4'hF;

        // Reset during slot 2 SHOW with a pending load outstanding.
        cycle(1'b0, 1'b1, 16'h3333);
        run_to(2 * R + 4);
        cycle(1'b1, 1'b1, 16'h7777);
        check("midscan_rst_anode", anode, 4'hF);
        check("midscan_rst_encoded", encoded, 4'hF);
        run_to(3);
        check("post_rst_encoded", encoded, 4'h0);
        check("post_rst_anode", anode, 4'b1110);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic        r;
            logic        l;
            logic [15:0] d;
            r = ($urandom_range(0, 399) == 0);
            l = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       d = 16'($urandom_range(0, 15));
                1:       d = 16'($urandom_range(0, 255));
                default: d = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) en = 4'($urandom);
            else if ($urandom_range(0, 7) == 0) en = 4'hF;
            if ($urandom_range(0, 15) == 0) blz = 1'($urandom);
            cycle(r, l, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of multiplexed digits (range 2..8).
REQ-003 The block SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot; it SHALL be >= BLANK_CYCLES+2.
REQ-004 The block SHALL have parameter BLANK_CYCLES, default 1000, giving the anti-ghosting gap at the start of each slot; it SHALL be >= 1.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 load  input  1  single-cycle strobe that captures digits_in.
REQ-008 digits_in  input  4*NUM_DIGITS  BCD nibbles; nibble i at [4i+3:4i]; digit NUM_DIGITS-1 is most significant.
REQ-009 digit_en  input  NUM_DIGITS  per-digit enable; 0 forces that digit dark.
REQ-010 blank_lz  input  1  1 enables leading-zero blanking.
REQ-011 encoded  output  4  nibble for the downstream cathode decoder; 4'hF means dark.
REQ-012 anode  output  NUM_DIGITS  active-low one-hot digit select.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 The block SHALL hold a pending register (digits plus pending_valid) and an active register used for display.
REQ-015 load=1 SHALL write digits_in to pending and set pending_valid in the same edge; repeated loads before a frame boundary SHALL keep only the last one.
REQ-016 A counter div_cnt SHALL count 0..REFRESH_DIV-1 and wrap; digit index idx SHALL increment when div_cnt wraps, going from NUM_DIGITS-1 to 0.
REQ-017 The phase FSM SHALL be in BLANK while div_cnt < BLANK_CYCLES and in SHOW otherwise; it SHALL have no other states.
REQ-018 frame_done SHALL be 1 for exactly the cycle after idx wraps from NUM_DIGITS-1 to 0, and 0 otherwise.
REQ-019 On the edge where idx wraps to 0, if pending_valid=1, active SHALL take pending and pending_valid SHALL clear.
REQ-020 If load is 1 on that same edge, active SHALL take the old pending value and pending SHALL take digits_in with pending_valid=1.
REQ-021 Digit i SHALL be LZ-blanked when blank_lz=1, i!=0, and all active nibbles j>=i equal 0; digit 0 SHALL never be LZ-blanked.
REQ-022 Digit idx is lit when phase=SHOW, digit_en[idx]=1, and the digit is not LZ-blanked.
REQ-023 When lit, anode SHALL equal ~(1<<idx) and encoded SHALL equal active nibble idx; otherwise anode SHALL be all ones and encoded SHALL be 4'hF.
REQ-024 anode and encoded SHALL be combinational from the registered idx, phase and active state, plus the digit_en and blank_lz inputs, with zero latency; no two anode bits SHALL be low at the same time.
REQ-025 Active nibbles above 9 SHALL be passed through unchanged; display mapping is the downstream decoder's job.

Reset
REQ-026 While rst=1, on each edge: div_cnt=0, idx=0, phase=BLANK, active=0, pending=0, pending_valid=0, frame_done=0.
REQ-027 During and after reset, anode SHALL be all ones and encoded 4'hF until the first SHOW phase.
REQ-028 Reset asserted mid-slot or mid-frame SHALL abandon the scan and discard any pending load.
REQ-029 rst SHALL take priority over load on the same edge.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-030 Release reset, then load 16'h4321 with all enables set and blank_lz=0 -> after the first frame_done: slot 0 has anode 4'b1111 for 2 cycles, then 4'b1110 with encoded 1 for 6 cycles; slots 1..3 show 2, 3, 4.
REQ-031 Load 16'h0050 with blank_lz=1 -> digits 3 and 2 dark (encoded F, anode all ones); digits 1 and 0 show 5 and 0. Load 16'h0000 -> only digit 0 is lit, showing 0.
REQ-032 Load 16'h1111 mid-frame, then load 16'h2222 one cycle before the wrap -> the next frame shows 2222 only, with no tearing within the frame.
REQ-033 Load coincident with the wrap edge while pending holds 16'h5555 -> that frame shows 5555; the following frame shows the new value.
REQ-034 digit_en=4'b0101 -> slots 1 and 3 have anode all ones and encoded F; frame_done pulses every 32 cycles.
REQ-035 Assert rst during slot 2 SHOW -> next edge anode=4'b1111, encoded=F, idx=0, and a subsequent frame shows 0000 (blank_lz=0).
